// File: rtl/input_buffer_ctrl_pkg.sv
// Shared definitions for the router input-port front end: address slices,
// flit field positions and FSM state encodings.
package input_buffer_ctrl_pkg;

   localparam int ADDR_W    = 8;
   localparam int ADDR_X_HI = 7;
   localparam int ADDR_X_LO = 4;
   localparam int ADDR_Y_HI = 3;
   localparam int ADDR_Y_LO = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_XFER = 2'd3;

   // Flit layout is {head, tail, payload}: head is the MSB, tail just below it.
   function automatic int head_bit(input int payload_w);
      return payload_w + 1;
   endfunction

   function automatic int tail_bit(input int payload_w);
      return payload_w;
   endfunction

endpackage

// File: rtl/input_buffer_ctrl_flit_fifo.sv
// Synchronous flit FIFO with extra-MSB pointers for full/empty detection.
module flit_fifo #(
   parameter int DATA_W = 18,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       wr_ptr_d;
   logic [AW:0]       rd_ptr_q;
   logic [AW:0]       rd_ptr_d;
   logic              do_push;
   logic              do_pop;

   // A push into a full FIFO is refused even if a pop happens in the same cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance; the power-of-two depth makes the low bits wrap at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers; reset empties the FIFO at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/input_buffer_ctrl.sv
// Router input-port front end: buffers flits, requests the output for each
// packet head, then streams the packet to the crossbar once granted.
module input_buffer_ctrl
   import input_buffer_ctrl_pkg::*;
#(
   parameter int PAYLOAD_W  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W+1:0] in_flit,
   output logic                 in_ready,
   output logic                 rqs_strobe,
   output logic [ADDR_W-1:0]    addr,
   input  logic                 arb_ack,
   output logic                 out_valid,
   output logic [PAYLOAD_W+1:0] out_flit,
   input  logic                 out_ready,
   output logic                 xfer_done,
   output logic                 proto_err
);

   localparam int FLIT_W = PAYLOAD_W + 2;
   localparam int HEAD_B = head_bit(PAYLOAD_W);
   localparam int TAIL_B = tail_bit(PAYLOAD_W);

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic              proto_err_q;
   logic              proto_err_d;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FLIT_W-1:0] front;

   assign in_ready  = ~fifo_full;
   assign fifo_push = in_valid & ~fifo_full;
   assign proto_err = proto_err_q;

   flit_fifo #(
      .DATA_W (FLIT_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (in_flit),
      .dout  (front),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Destination of the front header; forced to zero while nothing is buffered.
   always_comb begin
      if (fifo_empty) begin
         addr = {ADDR_W{1'b0}};
      end else begin
         addr = {front[ADDR_X_HI:ADDR_X_LO], front[ADDR_Y_HI:ADDR_Y_LO]};
      end
   end

   // Flit toward the crossbar is the FIFO front, only while it is offered.
   always_comb begin
      if (out_valid) begin
         out_flit = front;
      end else begin
         out_flit = {FLIT_W{1'b0}};
      end
   end

   // Packet FSM next-state and strobes. In IDLE an incoming head written into an
   // empty FIFO moves straight to REQ so the strobe lands the cycle after the push.
   always_comb begin
      state_d     = state_q;
      proto_err_d = proto_err_q;
      fifo_pop    = 1'b0;
      rqs_strobe  = 1'b0;
      out_valid   = 1'b0;
      xfer_done   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (front[HEAD_B]) begin
                  state_d = ST_REQ;
               end else begin
                  fifo_pop    = 1'b1;
                  proto_err_d = 1'b1;
               end
            end else if (fifo_push && in_flit[HEAD_B]) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            rqs_strobe = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (arb_ack) begin
               state_d = ST_XFER;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_XFER: begin
            out_valid = ~fifo_empty;
            if (out_valid && out_ready) begin
               fifo_pop = 1'b1;
               if (front[TAIL_B]) begin
                  xfer_done = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_XFER;
               end
            end else begin
               state_d = ST_XFER;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and sticky protocol-error flag; only reset clears the flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule
